// File: rtl/serv_alu_seq.sv
// Digit-serial ALU: one XLEN-bit operation per start/ready handshake, W bits per beat LSB-first,
// plus bit-per-cycle shifts and a registered result/valid interface.
module serv_alu_seq #(
  parameter int XLEN = 32,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_ready,
  output logic            o_busy,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_op_b,
  output logic [XLEN-1:0] o_rd,
  output logic            o_cmp,
  output logic            o_valid
);
  localparam int N  = XLEN / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  if ((XLEN % W) != 0) begin : g_bad_div
    $error("serv_alu_seq: XLEN must be a multiple of W");
  end
  if (!((W == 1) || (W == 2) || (W == 4) || (W == 8) || (W == 16) || (W == 32))) begin : g_bad_w
    $error("serv_alu_seq: W must be one of 1, 2, 4, 8, 16, 32");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU) || (op == OP_EQ);
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  state_t          state_r;
  logic [3:0]      op_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] res_r;
  logic [CW-1:0]   cnt_r;
  logic [SW-1:0]   shcnt_r;
  logic            carry_r;
  logic            eq_r;

  logic            accept_s;
  logic            last_s;
  logic            lt_s;
  logic            eq_next_s;
  logic            slt_s;
  logic [W-1:0]    a_dig_s;
  logic [W-1:0]    b_dig_s;
  logic [W-1:0]    b_x_s;
  logic [W-1:0]    res_dig_s;
  logic [W:0]      sum_s;
  logic [XLEN-1:0] res_next_s;
  logic [XLEN-1:0] shifted_s;
  logic [SW-1:0]   shamt_s;

  // Per-beat digit datapath and single-bit shifter
  always_comb begin
    accept_s  = i_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    shamt_s   = i_op_b[SW-1:0];
    a_dig_s   = a_r[W-1:0];
    b_dig_s   = b_r[W-1:0];
    b_x_s     = b_dig_s ^ {W{is_sub(op_r)}};
    sum_s     = {1'b0, a_dig_s} + {1'b0, b_x_s} + {{W{1'b0}}, carry_r};
    eq_next_s = eq_r & (a_dig_s == b_dig_s);
    last_s    = (cnt_r == CW'(N - 1));
    slt_s     = (op_r == OP_SLT);
    // Sign-extend both operands by one bit (SLT only); bit XLEN of A - B is the less-than flag
    lt_s      = (slt_s & a_dig_s[W-1]) ^ ~(slt_s & b_dig_s[W-1]) ^ sum_s[W];
    res_dig_s = {W{1'b0}};
    case (op_r)
      OP_ADD, OP_SUB: res_dig_s = sum_s[W-1:0];
      OP_XOR:         res_dig_s = a_dig_s ^ b_dig_s;
      OP_OR:          res_dig_s = a_dig_s | b_dig_s;
      OP_AND:         res_dig_s = a_dig_s & b_dig_s;
      default:        res_dig_s = {W{1'b0}};
    endcase
    res_next_s = (res_r >> W) | (XLEN'(res_dig_s) << (XLEN - W));
    shifted_s  = res_r;
    case (op_r)
      OP_SLL:  shifted_s = res_r << 1;
      OP_SRL:  shifted_s = res_r >> 1;
      OP_SRA:  shifted_s = {res_r[XLEN-1], res_r[XLEN-1:1]};
      default: shifted_s = res_r;
    endcase
  end

  // Control FSM, operand/accumulator registers and registered outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      op_r    <= 4'd0;
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      res_r   <= {XLEN{1'b0}};
      cnt_r   <= {CW{1'b0}};
      shcnt_r <= {SW{1'b0}};
      carry_r <= 1'b0;
      eq_r    <= 1'b0;
      o_rd    <= {XLEN{1'b0}};
      o_cmp   <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            op_r    <= i_op;
            a_r     <= i_rs1;
            b_r     <= i_op_b;
            cnt_r   <= {CW{1'b0}};
            shcnt_r <= shamt_s;
            carry_r <= is_sub(i_op);
            eq_r    <= 1'b1;
            if (is_shift(i_op)) begin
              res_r <= i_rs1;
              if (shamt_s == {SW{1'b0}}) begin
                state_r <= ST_DONE;
                o_rd    <= i_rs1;
                o_cmp   <= 1'b0;
                o_valid <= 1'b1;
                o_busy  <= 1'b0;
                o_ready <= 1'b1;
              end else begin
                state_r <= ST_SHIFT;
                o_busy  <= 1'b1;
                o_ready <= 1'b0;
              end
            end else begin
              res_r   <= {XLEN{1'b0}};
              state_r <= ST_RUN;
              o_busy  <= 1'b1;
              o_ready <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> W;
          b_r     <= b_r >> W;
          carry_r <= sum_s[W];
          eq_r    <= eq_next_s;
          res_r   <= res_next_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            state_r <= ST_DONE;
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
            case (op_r)
              OP_SLT, OP_SLTU: begin
                o_rd  <= XLEN'(lt_s);
                o_cmp <= lt_s;
              end
              OP_EQ: begin
                o_rd  <= XLEN'(eq_next_s);
                o_cmp <= eq_next_s;
              end
              default: begin
                o_rd  <= res_next_s;
                o_cmp <= 1'b0;
              end
            endcase
          end
        end
        ST_SHIFT: begin
          res_r   <= shifted_s;
          shcnt_r <= shcnt_r - SW'(1);
          if (shcnt_r == SW'(1)) begin
            state_r <= ST_DONE;
            o_rd    <= shifted_s;
            o_cmp   <= 1'b0;
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serv_alu_seq.sv
// Bench for serv_alu_seq: three instances (W=8, 1, 32) share stimulus and are checked
// against an arithmetic reference model for result, compare flag, latency and busy time.
module tb_serv_alu_seq;
  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_op_b;
  logic        ready_s [3];
  logic        busy_s  [3];
  logic [31:0] rd_s    [3];
  logic        cmp_s   [3];
  logic        valid_s [3];

  int n_cmp = 0;
  int n_bad = 0;
  int wd [3] = '{8, 1, 32};

  serv_alu_seq #(.XLEN(32), .W(8)) u_dut8 (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .o_ready(ready_s[0]), .o_busy(busy_s[0]),
    .i_op(i_op), .i_rs1(i_rs1), .i_op_b(i_op_b), .o_rd(rd_s[0]), .o_cmp(cmp_s[0]), .o_valid(valid_s[0]));
  serv_alu_seq #(.XLEN(32), .W(1)) u_dut1 (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .o_ready(ready_s[1]), .o_busy(busy_s[1]),
    .i_op(i_op), .i_rs1(i_rs1), .i_op_b(i_op_b), .o_rd(rd_s[1]), .o_cmp(cmp_s[1]), .o_valid(valid_s[1]));
  serv_alu_seq #(.XLEN(32), .W(32)) u_dut32 (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .o_ready(ready_s[2]), .o_busy(busy_s[2]),
    .i_op(i_op), .i_rs1(i_rs1), .i_op_b(i_op_b), .o_rd(rd_s[2]), .o_cmp(cmp_s[2]), .o_valid(valid_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a | b;
      4'd6:    return a & b;
      4'd7:    return (a == b) ? 32'd1 : 32'd0;
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      4'd10:   return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = ref_rd(op, a, b);
    return ((op == 4'd2) || (op == 4'd3) || (op == 4'd7)) ? r[0] : 1'b0;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b, input int w);
    if ((op == 4'd8) || (op == 4'd9) || (op == 4'd10))
      return (b[4:0] == 5'd0) ? 1 : 1 + int'(b[4:0]);
    return 32 / w + 1;
  endfunction

  // Issue one op to all instances and check each one's result, flag, latency and busy span.
  // With poke set, a junk request is held for the cycle after accept and must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    int          lat  [3];
    int          bcnt [3];
    bit          seen [3];
    logic [31:0] grd  [3];
    logic        gcmp [3];
    int          k;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; bcnt[d] = 0; seen[d] = 1'b0; grd[d] = 32'd0; gcmp[d] = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_ready"}, {29'd0, ready_s[2], ready_s[1], ready_s[0]}, 32'd7);
    i_op = op; i_rs1 = a; i_op_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_op = 4'($urandom); i_rs1 = $urandom; i_op_b = $urandom;
    k = 1;
    while (k <= 80) begin
      if (poke && (k == 1)) begin
        i_start = 1'b1; i_op = 4'd1; i_rs1 = $urandom; i_op_b = $urandom;
      end
      if (poke && (k == 2)) i_start = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d]) begin
          if (valid_s[d]) begin
            seen[d] = 1'b1; lat[d] = k; grd[d] = rd_s[d]; gcmp[d] = cmp_s[d];
          end else if (busy_s[d]) begin
            bcnt[d]++;
          end
        end
      end
      if (seen[0] && seen[1] && seen[2] && (k > 2)) break;
      @(posedge clk); #1;
      k++;
    end
    i_start = 1'b0;
    for (int d = 0; d < 3; d++) begin
      string t;
      t = $sformatf("%s_w%0d", tag, wd[d]);
      chk({t, "_seen"}, {31'd0, seen[d]}, 32'd1);
      chk({t, "_rd"}, grd[d], ref_rd(op, a, b));
      chk({t, "_cmp"}, {31'd0, gcmp[d]}, {31'd0, ref_cmp(op, a, b)});
      chk({t, "_lat"}, lat[d], ref_lat(op, b, wd[d]));
      chk({t, "_busy"}, bcnt[d], ref_lat(op, b, wd[d]) - 1);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {29'd0, valid_s[2], valid_s[1], valid_s[0]}, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    int          bad;
    i_rst = 1'b1; i_start = 1'b0; i_op = 4'd0; i_rs1 = 32'd0; i_op_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rd_w%0d", wd[d]), rd_s[d], 32'd0);
      chk($sformatf("rst_flags_w%0d", wd[d]),
          {27'd0, ready_s[d], busy_s[d], valid_s[d], cmp_s[d], 1'b0}, 32'b10000);
    end
    @(negedge clk);
    i_rst = 1'b0;

    run_op("add",    4'd0,  32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op("slt",    4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sltu",   4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub",    4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("eq",     4'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    run_op("neq",    4'd7,  32'hDEAD_BEEF, 32'h5EAD_BEEF, 1'b0);
    run_op("sra",    4'd10, 32'h8000_0000, 32'h0000_0004, 1'b0);
    run_op("srl",    4'd9,  32'h8000_0000, 32'h0000_0004, 1'b0);
    run_op("sll",    4'd8,  32'h0000_0001, 32'h0000_001F, 1'b0);
    run_op("sh0",    4'd8,  32'h1234_5678, 32'h0000_0020, 1'b0);
    run_op("rsvd",   4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("ignore", 4'd0,  32'h1111_1111, 32'h2222_2222, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op($sformatf("rnd%0d", i), op, a, b, 1'b0);
    end

    // Back-to-back on the W=8 instance: second request presented in its DONE cycle
    @(negedge clk);
    a = $urandom; b = $urandom;
    i_op = 4'd4; i_rs1 = a; i_op_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    k = 1;
    while (!valid_s[0] && (k < 60)) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_lat1", k, 32'd5);
    chk("b2b_rd1", rd_s[0], a ^ b);
    a = $urandom; b = $urandom;
    i_op = 4'd0; i_rs1 = a; i_op_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("b2b_busy", {31'd0, busy_s[0]}, 32'd1);
    k = 1;
    while (!valid_s[0] && (k < 60)) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_lat2", k, 32'd5);
    chk("b2b_rd2", rd_s[0], a + b);
    repeat (40) @(posedge clk);

    // Reset two cycles into an ADD aborts it
    @(negedge clk);
    i_op = 4'd0; i_rs1 = 32'h0000_00FF; i_op_b = 32'h0000_0001; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_rd_w%0d", wd[d]), rd_s[d], 32'd0);
      chk($sformatf("abort_flags_w%0d", wd[d]),
          {29'd0, ready_s[d], busy_s[d], valid_s[d]}, 32'b100);
    end
    @(negedge clk);
    i_rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_s[0] || valid_s[1] || valid_s[2]) bad++;
    end
    chk("abort_novalid", bad, 32'd0);
    chk("abort_rd_hold", rd_s[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
